// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: display-side receiver for the four-wire write-only SPI display bus.
// Latency: 3 Clock edges from the first edge that samples the 8th SCLK high to RxValid.
// Backpressure: bytes queue in a FIFO_DEPTH-entry FIFO; a byte completing while it is full is dropped and flags Overflow.
//
// Ports:
//   Clock, nReset          system clock, asynchronous active-low reset
//   SCLK, nCS, SDIN, DnC   asynchronous bus inputs (mode 0, MSB first)
//   RxData, RxDnC          head byte and its command/data tag
//   RxValid, RxReady       output handshake; pop when both are high
//   Overflow, FrameError   sticky error flags, cleared by ClearErrors

// oled_spi_sync2: two-flop synchroniser with a configurable reset value.
// Latency: 2 clk edges.
// Backpressure: none.
module oled_spi_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// oled_spi_fifo: small register FIFO whose head entry is read straight from the storage array.
// Latency: a push is visible at the head (not_empty) right after the writing edge.
// Backpressure: push_ok is low when full, unless a pop frees an entry on the same edge.
module oled_spi_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic             push_ok,
   output logic [WIDTH-1:0] head_dat,
   output logic             not_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             pop_ok;

   assign not_empty = (count != '0);
   assign pop_ok    = pop && not_empty;
   // A full FIFO still takes the byte when the head leaves on the same edge.
   assign push_ok   = push && ((count < (AW+1)'(DEPTH)) || pop_ok);
   assign head_dat  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_ok && !pop_ok) begin
            count <= count + (AW+1)'(1);
         end else if (!push_ok && pop_ok) begin
            count <= count - (AW+1)'(1);
         end
      end
   end
endmodule

// oled_spi_receiver: SPI display-bus deserialiser with tagged byte FIFO and sticky error flags.
// Latency: 3 Clock edges pin-to-valid (2 sync + 1 FIFO write).
// Backpressure: RxValid/RxReady; bytes arriving while the FIFO is full are dropped (Overflow).
module oled_spi_receiver #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       Clock,
   input  logic       nReset,
   input  logic       SCLK,
   input  logic       nCS,
   input  logic       SDIN,
   input  logic       DnC,
   output logic [7:0] RxData,
   output logic       RxDnC,
   output logic       RxValid,
   input  logic       RxReady,
   output logic       Overflow,
   output logic       FrameError,
   input  logic       ClearErrors
);
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t     state_q;
   state_t     state_nxt;

   logic       sclk_s;
   logic       ncs_s;
   logic       sdin_s;
   logic       dnc_s;
   logic       sclk_d;
   logic       rise_sclk;

   logic [6:0] shift_reg;
   logic [2:0] bit_cnt;

   logic       shift_en;
   logic       clr_cnt;
   logic       push_req;
   logic       frame_err_set;
   logic       push_ok;
   logic       pop;
   logic [8:0] push_dat;
   logic [8:0] head_dat;

   // Bus synchronisers; reset values match an idle, deselected bus.
   oled_spi_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(Clock), .rst_n(nReset), .d(SCLK), .q(sclk_s));
   oled_spi_sync2 #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(Clock), .rst_n(nReset), .d(nCS),  .q(ncs_s));
   oled_spi_sync2 #(.RST_VAL(1'b0)) u_sync_sdin (.clk(Clock), .rst_n(nReset), .d(SDIN), .q(sdin_s));
   oled_spi_sync2 #(.RST_VAL(1'b0)) u_sync_dnc  (.clk(Clock), .rst_n(nReset), .d(DnC),  .q(dnc_s));

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sclk_d <= 1'b0;
      end else begin
         sclk_d <= sclk_s;
      end
   end

   assign rise_sclk = sclk_s && !sclk_d;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      shift_en      = 1'b0;
      clr_cnt       = 1'b0;
      push_req      = 1'b0;
      frame_err_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            clr_cnt = 1'b1;
            if (!ncs_s) begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Deselect takes priority over a coincident SCLK edge.
            if (ncs_s) begin
               state_nxt     = ST_IDLE;
               clr_cnt       = 1'b1;
               frame_err_set = (bit_cnt != 3'd0);
            end else if (rise_sclk) begin
               shift_en = 1'b1;
               push_req = (bit_cnt == 3'd7);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (shift_en) begin
         shift_reg <= {shift_reg[5:0], sdin_s};
         bit_cnt   <= bit_cnt + 3'd1;
      end else if (clr_cnt) begin
         bit_cnt   <= '0;
      end
   end

   // The completing byte takes the 8th bit and the tag straight from the synchronisers.
   assign push_dat = {dnc_s, shift_reg, sdin_s};
   assign pop      = RxValid && RxReady;

   oled_spi_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (Clock),
      .rst_n     (nReset),
      .push      (push_req),
      .push_dat  (push_dat),
      .pop       (pop),
      .push_ok   (push_ok),
      .head_dat  (head_dat),
      .not_empty (RxValid)
   );

   assign RxData = head_dat[7:0];
   assign RxDnC  = head_dat[8];

   // Sticky flags: a set event on the same edge beats ClearErrors.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         Overflow   <= 1'b0;
         FrameError <= 1'b0;
      end else begin
         if (push_req && !push_ok) begin
            Overflow <= 1'b1;
         end else if (ClearErrors) begin
            Overflow <= 1'b0;
         end
         if (frame_err_set) begin
            FrameError <= 1'b1;
         end else if (ClearErrors) begin
            FrameError <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_oled_spi_receiver.sv
// tb_oled_spi_receiver: self-checking bench for oled_spi_receiver.
// Drives the SPI bus at 8 Clock periods per SCLK period; a scoreboard queue holds expected bytes.
// Directed sequences cover latency, overflow, frame error, pop-with-push and mid-byte reset.
module tb_oled_spi_receiver;
   logic       Clock       = 1'b0;
   logic       nReset      = 1'b0;
   logic       SCLK        = 1'b0;
   logic       nCS         = 1'b1;
   logic       SDIN        = 1'b0;
   logic       DnC         = 1'b0;
   logic       RxReady     = 1'b0;
   logic       ClearErrors = 1'b0;
   logic [7:0] RxData;
   logic       RxDnC;
   logic       RxValid;
   logic       Overflow;
   logic       FrameError;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;

   typedef struct {
      logic [7:0] din;
      logic       dnc;
      logic [7:0] exp_dat;
      logic       exp_dnc;
   } vec_t;

   vec_t vecs[6];

   oled_spi_receiver #(.FIFO_DEPTH(4)) dut (
      .Clock       (Clock),
      .nReset      (nReset),
      .SCLK        (SCLK),
      .nCS         (nCS),
      .SDIN        (SDIN),
      .DnC         (DnC),
      .RxData      (RxData),
      .RxDnC       (RxDnC),
      .RxValid     (RxValid),
      .RxReady     (RxReady),
      .Overflow    (Overflow),
      .FrameError  (FrameError),
      .ClearErrors (ClearErrors)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: sample 1 ns before each rising edge; a handshake seen here pops on that edge.
   always begin
      @(negedge Clock);
      #4;
      if (nReset && RxValid && RxReady) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got %0h expected none", {RxDnC, RxData});
         end else begin
            mon_e = exp_q.pop_front();
            check("pop_byte", 32'({RxDnC, RxData}), 32'(mon_e));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic start_frame();
      @(negedge Clock);
      nCS = 1'b0;
      repeat (4) @(negedge Clock);
   endtask

   task automatic end_frame();
      repeat (4) @(negedge Clock);
      nCS = 1'b1;
      repeat (4) @(negedge Clock);
   endtask

   // mode 0: plain; mode 1: check 3-edge latency on 8th bit; mode 2: raise RxReady just before FIFO write.
   task automatic send_bits(input logic [7:0] b, input logic dnc, input int nbits, input int mode);
      for (int i = 0; i < nbits; i++) begin
         SDIN = b[7-i];
         DnC  = dnc;
         repeat (4) @(negedge Clock);
         SCLK = 1'b1;
         if (i == 7 && mode == 1) begin
            @(posedge Clock); #1;
            check("lat_after_t0", 32'(RxValid), 32'd0);
            @(posedge Clock); #1;
            check("lat_after_t1", 32'(RxValid), 32'd0);
            @(posedge Clock); #1;
            check("lat_after_t2", 32'(RxValid), 32'd1);
            check("lat_data", 32'(RxData), 32'(b));
            check("lat_dnc", 32'(RxDnC), 32'(dnc));
            repeat (2) @(negedge Clock);
         end else if (i == 7 && mode == 2) begin
            @(posedge Clock);
            @(posedge Clock);
            @(negedge Clock);
            RxReady = 1'b1;
            repeat (2) @(negedge Clock);
         end else begin
            repeat (4) @(negedge Clock);
         end
         SCLK = 1'b0;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
         @(negedge Clock);
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge Clock);
   endtask

   task automatic pulse_clear();
      @(negedge Clock);
      ClearErrors = 1'b1;
      @(negedge Clock);
      ClearErrors = 1'b0;
      @(negedge Clock);
   endtask

   initial begin
      vecs[0] = '{din: 8'h3C, dnc: 1'b1, exp_dat: 8'h3C, exp_dnc: 1'b1};
      vecs[1] = '{din: 8'h81, dnc: 1'b0, exp_dat: 8'h81, exp_dnc: 1'b0};
      vecs[2] = '{din: 8'h00, dnc: 1'b1, exp_dat: 8'h00, exp_dnc: 1'b1};
      vecs[3] = '{din: 8'hFF, dnc: 1'b0, exp_dat: 8'hFF, exp_dnc: 1'b0};
      vecs[4] = '{din: 8'h55, dnc: 1'b1, exp_dat: 8'h55, exp_dnc: 1'b1};
      vecs[5] = '{din: 8'hAA, dnc: 1'b0, exp_dat: 8'hAA, exp_dnc: 1'b0};

      // Reset state
      repeat (3) @(negedge Clock);
      check("rst_valid", 32'(RxValid), 32'd0);
      check("rst_data", 32'(RxData), 32'd0);
      check("rst_dnc", 32'(RxDnC), 32'd0);
      check("rst_overflow", 32'(Overflow), 32'd0);
      check("rst_frameerr", 32'(FrameError), 32'd0);
      nReset = 1'b1;
      repeat (3) @(negedge Clock);
      check("post_rst_valid", 32'(RxValid), 32'd0);

      // Single command byte with exact latency, then one-cycle pop
      start_frame();
      exp_q.push_back({1'b0, 8'hA5});
      send_bits(8'hA5, 1'b0, 8, 1);
      end_frame();
      @(negedge Clock);
      RxReady = 1'b1;
      @(posedge Clock); #1;
      check("pop_clears_valid", 32'(RxValid), 32'd0);
      @(negedge Clock);

      // Table: back-to-back bytes in one frame
      start_frame();
      for (int v = 0; v < 6; v++) begin
         exp_q.push_back({vecs[v].exp_dnc, vecs[v].exp_dat});
         send_bits(vecs[v].din, vecs[v].dnc, 8, 0);
      end
      end_frame();
      wait_drain();
      check("tbl_overflow", 32'(Overflow), 32'd0);
      check("tbl_frameerr", 32'(FrameError), 32'd0);

      // Overflow: five bytes into a depth-4 FIFO
      RxReady = 1'b0;
      start_frame();
      for (int b = 1; b <= 5; b++) begin
         if (b <= 4) exp_q.push_back({1'b1, 8'(b)});
         send_bits(8'(b), 1'b1, 8, 0);
      end
      end_frame();
      check("ovf_flag", 32'(Overflow), 32'd1);
      check("ovf_frameerr", 32'(FrameError), 32'd0);
      check("ovf_head", 32'(RxData), 32'h01);
      RxReady = 1'b1;
      wait_drain();
      check("ovf_empty", 32'(RxValid), 32'd0);
      pulse_clear();
      check("ovf_cleared", 32'(Overflow), 32'd0);

      // Frame error: 5 bits then deselect
      RxReady = 1'b0;
      start_frame();
      send_bits(8'hB0, 1'b1, 5, 0);
      end_frame();
      check("ferr_flag", 32'(FrameError), 32'd1);
      check("ferr_no_push", 32'(RxValid), 32'd0);
      RxReady = 1'b1;
      start_frame();
      exp_q.push_back({1'b1, 8'h7E});
      send_bits(8'h7E, 1'b1, 8, 0);
      end_frame();
      wait_drain();
      check("ferr_sticky", 32'(FrameError), 32'd1);
      pulse_clear();
      check("ferr_cleared", 32'(FrameError), 32'd0);

      // Full FIFO: 5th byte lands on the same edge as a pop
      RxReady = 1'b0;
      start_frame();
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back({1'b0, 8'(8'h10 + b)});
         send_bits(8'(8'h10 + b), 1'b0, 8, 0);
      end
      exp_q.push_back({1'b1, 8'h14});
      send_bits(8'h14, 1'b1, 8, 2);
      end_frame();
      wait_drain();
      check("pp_overflow", 32'(Overflow), 32'd0);
      check("pp_empty", 32'(RxValid), 32'd0);

      // Reset mid-byte with a byte waiting in the FIFO
      RxReady = 1'b0;
      start_frame();
      send_bits(8'h11, 1'b1, 8, 0);
      send_bits(8'h99, 1'b0, 4, 0);
      check("rst2_pre_valid", 32'(RxValid), 32'd1);
      @(negedge Clock);
      nReset = 1'b0;
      nCS    = 1'b1;
      #1;
      check("rst2_valid", 32'(RxValid), 32'd0);
      check("rst2_data", 32'(RxData), 32'd0);
      check("rst2_dnc", 32'(RxDnC), 32'd0);
      check("rst2_overflow", 32'(Overflow), 32'd0);
      check("rst2_frameerr", 32'(FrameError), 32'd0);
      repeat (2) @(negedge Clock);
      nReset = 1'b1;
      repeat (4) @(negedge Clock);
      check("rst2_after_ferr", 32'(FrameError), 32'd0);
      check("rst2_after_valid", 32'(RxValid), 32'd0);
      RxReady = 1'b1;
      start_frame();
      exp_q.push_back({1'b1, 8'hC3});
      send_bits(8'hC3, 1'b1, 8, 0);
      end_frame();
      wait_drain();
      check("rst2_final_ferr", 32'(FrameError), 32'd0);
      check("rst2_final_ovf", 32'(Overflow), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
